// File: rtl/asic_cfg_loader.sv
// Frame assembler for DYNCNF/STATCNF: header, 13 payload bytes, check byte; commits on a good frame.
// Define CFG_CRC8_EN to use a CRC-8 (poly 0x07) check byte instead of the XOR checksum.
module asic_cfg_loader #(
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [15:0] DYN_INIT       = 16'hABC6,
    parameter logic [87:0] STAT_INIT      = 88'h123456789ABCDEF1234567
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cfg_clr,
    output logic [15:0] dyncnf,
    output logic [87:0] statcnf,
    output logic        cfg_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DYN    = 3'd1,
        ST_STAT   = 3'd2,
        ST_CHK    = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
`ifdef CFG_CRC8_EN
        logic [7:0] c;
        c = chk ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
`else
        return chk ^ data;
`endif
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    state_t         state_r;
    logic [3:0]     idx_r;
    logic [7:0]     chk_r;
    logic [TW-1:0]  tmo_r;
    logic [15:0]    shadow_dyn_r;
    logic [87:0]    shadow_stat_r;
    logic [15:0]    dyncnf_r;
    logic [87:0]    statcnf_r;
    logic           cfg_valid_r;
    logic           frame_err_r;
    logic           busy_r;
    logic [7:0]     err_cnt_r;
    logic [7:0]     chk_next_s;

    assign chk_next_s = chk_update(chk_r, rx_data);

    // Frame FSM, shadow assembly, inter-byte timeout and committed outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= ST_IDLE;
            idx_r         <= 4'd0;
            chk_r         <= 8'h00;
            tmo_r         <= '0;
            shadow_dyn_r  <= 16'h0000;
            shadow_stat_r <= 88'h0;
            dyncnf_r      <= DYN_INIT;
            statcnf_r     <= STAT_INIT;
            cfg_valid_r   <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
            err_cnt_r     <= 8'h00;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == HEADER_BYTE)) begin
                        state_r       <= ST_DYN;
                        idx_r         <= 4'd0;
                        chk_r         <= 8'h00;
                        tmo_r         <= '0;
                        shadow_dyn_r  <= 16'h0000;
                        shadow_stat_r <= 88'h0;
                        busy_r        <= 1'b1;
                    end
                end
                ST_DYN: begin
                    if (rx_valid) begin
                        shadow_dyn_r <= {shadow_dyn_r[7:0], rx_data};
                        chk_r        <= chk_next_s;
                        if (idx_r == 4'd1) begin
                            state_r <= ST_STAT;
                            idx_r   <= 4'd0;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                ST_STAT: begin
                    if (rx_valid) begin
                        shadow_stat_r <= {shadow_stat_r[79:0], rx_data};
                        chk_r         <= chk_next_s;
                        if (idx_r == 4'd10) begin
                            state_r <= ST_CHK;
                            idx_r   <= 4'd0;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_r) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                            err_cnt_r   <= sat_inc(err_cnt_r);
                        end
                    end
                end
                ST_COMMIT: begin
                    dyncnf_r  <= shadow_dyn_r;
                    statcnf_r <= shadow_stat_r;
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            // Timeout only acts in cycles without a byte, so it never races the case above.
            if ((state_r == ST_DYN) || (state_r == ST_STAT) || (state_r == ST_CHK)) begin
                if (rx_valid) begin
                    tmo_r <= '0;
                end else if (tmo_r == TMO_LAST) begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    frame_err_r <= 1'b1;
                    err_cnt_r   <= sat_inc(err_cnt_r);
                end else begin
                    tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end

            if (state_r == ST_COMMIT) begin
                cfg_valid_r <= 1'b1;
            end else if (cfg_clr) begin
                cfg_valid_r <= 1'b0;
            end
        end
    end

    assign dyncnf    = dyncnf_r;
    assign statcnf   = statcnf_r;
    assign cfg_valid = cfg_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_asic_cfg_loader.sv
// Scoreboard bench for asic_cfg_loader: driver pushes expected frame outcomes, monitor checks at frame end.
module tb_asic_cfg_loader;

    localparam int          T    = 50000;
    localparam logic [7:0]  HDR  = 8'hA5;
    localparam logic [15:0] DI   = 16'hABC6;
    localparam logic [87:0] SI   = 88'h123456789ABCDEF1234567;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cfg_clr = 1'b0;
    logic [15:0] dyncnf;
    logic [87:0] statcnf;
    logic        cfg_valid;
    logic        frame_err;
    logic        busy;
    logic [7:0]  err_cnt;

    asic_cfg_loader dut (
        .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid), .cfg_clr(cfg_clr),
        .dyncnf(dyncnf), .statcnf(statcnf), .cfg_valid(cfg_valid), .frame_err(frame_err),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        logic [15:0] dyn;
        logic [87:0] stat;
        bit          cfgv;
        int          errc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // reference model state
    logic [15:0] m_dyn = DI;
    logic [87:0] m_stat = SI;
    bit          m_cfgv = 1'b0;
    int          m_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Check byte computed from the whole 104-bit payload message.
    function automatic logic [7:0] ref_check(input logic [103:0] msg);
        logic [7:0] r;
        r = 8'h00;
`ifdef CFG_CRC8_EN
        for (int b = 103; b >= 0; b--) begin
            logic fb;
            fb = r[7] ^ msg[b];
            r = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
`else
        for (int i = 0; i < 13; i++) r = r ^ msg[103 - 8*i -: 8];
`endif
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, output int c);
        repeat (gap) begin
            @(negedge CLK);
            rx_valid = 1'b0;
        end
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] dyn, input logic [87:0] stat,
                              input bit corrupt, input bit clr_commit, input int maxgap);
        logic [103:0] msg;
        logic [7:0]   chk;
        int           c;
        msg = {dyn, stat};
        chk = ref_check(msg);
        if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
        send_byte(HDR, $urandom_range(0, maxgap), c);
        for (int i = 0; i < 13; i++) send_byte(msg[103 - 8*i -: 8], $urandom_range(0, maxgap), c);
        send_byte(chk, $urandom_range(0, maxgap), c);
        if (corrupt) begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
            q.push_back('{c + 1, 1'b1, m_dyn, m_stat, m_cfgv, m_err});
        end else begin
            m_dyn  = dyn;
            m_stat = stat;
            m_cfgv = 1'b1;
            q.push_back('{c + 2, 1'b0, m_dyn, m_stat, m_cfgv, m_err});
        end
        if (clr_commit) begin
            @(negedge CLK);
            rx_valid = 1'b0;
            cfg_clr  = 1'b1;
            @(negedge CLK);
            cfg_clr  = 1'b0;
        end
        idle(2);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dyncnf"}, dyncnf, DI);
        check({tag, "_statcnf"}, statcnf, SI);
        check({tag, "_cfg_valid"}, cfg_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err_cnt"}, err_cnt, 8'h00);
        check({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    // Monitor: one expectation consumed per frame end; committed words must hold otherwise.
    bit          prev_busy = 1'b0;
    logic [15:0] mon_dyn = DI;
    logic [87:0] mon_stat = SI;
    exp_t        mon_e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_busy = 1'b0;
            mon_dyn   = DI;
            mon_stat  = SI;
        end else begin
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_end: unexpected frame end at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("end_cycle", cyc, mon_e.cyc);
                    check("end_frame_err", frame_err, mon_e.err);
                    check("end_dyncnf", dyncnf, mon_e.dyn);
                    check("end_statcnf", statcnf, mon_e.stat);
                    check("end_cfg_valid", cfg_valid, mon_e.cfgv);
                    check("end_err_cnt", err_cnt, mon_e.errc);
                    mon_dyn  = mon_e.dyn;
                    mon_stat = mon_e.stat;
                end
            end else begin
                check("no_stray_err", frame_err, 1'b0);
                check("hold_cfg", {dyncnf, statcnf}, {mon_dyn, mon_stat});
            end
            prev_busy = busy;
        end
    end

    initial begin
        int c;
        repeat (3) @(negedge CLK);
        check_reset_vals("reset");
        #1 RST_N = 1'b1;
        idle(2);

        // reference frame, then the same frame with a bad check byte
        send_frame(16'hABC6, 88'h123456789ABCDEF1234567, 1'b0, 1'b0, 0);
        idle(3);
        check("good_cfg_valid", cfg_valid, 1'b1);
        send_frame(16'hABC6, 88'h123456789ABCDEF1234567, 1'b1, 1'b0, 0);
        idle(3);
        check("bad_err_cnt", err_cnt, 8'd1);

        // stall after one DYN byte
        send_byte(HDR, 0, c);
        send_byte(8'h01, 0, c);
        m_err = m_err + 1;
        q.push_back('{c + 1 + T, 1'b1, m_dyn, m_stat, m_cfgv, m_err});
        idle(T + 5);
        check("tmo_busy", busy, 1'b0);
        check("tmo_err_cnt", err_cnt, 8'd2);
        send_frame(16'h5A3C, 88'h00FF00FF00FF00FF00FF00, 1'b0, 1'b0, 2);

        // lone clear, stray bytes, commit with a simultaneous clear, then a lone clear
        @(negedge CLK); cfg_clr = 1'b1;
        @(negedge CLK); cfg_clr = 1'b0;
        m_cfgv = 1'b0;
        check("lone_clr1", cfg_valid, 1'b0);
        send_byte(8'h00, 0, c);
        send_byte(8'hFF, 1, c);
        send_byte(8'h5A, 0, c);
        idle(3);
        check("stray_busy", busy, 1'b0);
        send_frame(16'h1234, 88'hFEDCBA9876543210012345, 1'b0, 1'b1, 1);
        check("clr_commit_valid", cfg_valid, 1'b1);
        check("clr_commit_dyn", dyncnf, 16'h1234);
        @(negedge CLK); cfg_clr = 1'b1;
        @(negedge CLK); cfg_clr = 1'b0;
        m_cfgv = 1'b0;
        check("lone_clr2", cfg_valid, 1'b0);

        // header bytes inside the payload are data
        send_frame(16'hA5A5, 88'hA5A5A5A5A5A5A5A5A5A5A5, 1'b0, 1'b0, 1);

        // reset after the 7th byte of a frame
        send_byte(HDR, 0, c);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 8'h30), 0, c);
        @(negedge CLK);
        rx_valid = 1'b0;
        #1 RST_N = 1'b0;
        #1 check_reset_vals("midreset");
        q.delete();
        m_dyn = DI; m_stat = SI; m_cfgv = 1'b0; m_err = 0;
        idle(2);
        #1 RST_N = 1'b1;
        idle(2);
        send_frame(16'hC0DE, 88'h0102030405060708090A0B, 1'b0, 1'b0, 0);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            send_frame(16'($urandom), 88'({$urandom, $urandom, $urandom}),
                       ($urandom_range(0, 3) == 0), 1'b0, 3);
        end

        for (int w = 0; w < 50 && q.size() > 0; w++) @(negedge CLK);
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
